// File: rtl/lieat_exu_wbck_pkg.sv
// Shared widths, grant encodings and the write-back entry layout for the
// execute-unit write-back stage and the commit logic that consumes it.
package lieat_exu_wbck_pkg;

  localparam int XLEN       = 32;
  localparam int RGIDX_SIZE = 5;

  // Encoding of the remembered round-robin winner, reused by commit.
  localparam logic LAST_GRANT_ALU    = 1'b0;
  localparam logic LAST_GRANT_MULDIV = 1'b1;

  // Bit positions inside the two-way grant vector.
  localparam int GNT_ALU    = 0;
  localparam int GNT_MULDIV = 1;

  typedef struct packed {
    logic [XLEN-1:0]       pc;
    logic [RGIDX_SIZE-1:0] rd;
    logic                  wen;
    logic [XLEN-1:0]       data;
  } wbck_entry_t;

  localparam int WBCK_ENTRY_W = $bits(wbck_entry_t);

  // x0 is hardwired to zero, so a write to it is dropped at the port.
  function automatic logic rf_write_allowed(input logic                  wen,
                                            input logic [RGIDX_SIZE-1:0] rd);
    return wen & (rd != '0);
  endfunction

endpackage

// File: rtl/lieat_exu_wbck_arb.sv
// Combinational two-way round-robin grant between the ALU and MUL/DIV
// result streams; on a tie the source that did not win last time is chosen.
module lieat_exu_wbck_arb
  import lieat_exu_wbck_pkg::*;
(
  input  logic       i_alu_valid,
  input  logic       i_muldiv_valid,
  input  logic       i_last_grant,
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant = 2'b00;
    unique case ({i_muldiv_valid, i_alu_valid})
      2'b01: o_grant[GNT_ALU]    = 1'b1;
      2'b10: o_grant[GNT_MULDIV] = 1'b1;
      2'b11: begin
        if (i_last_grant == LAST_GRANT_ALU) begin
          o_grant[GNT_MULDIV] = 1'b1;
        end else begin
          o_grant[GNT_ALU] = 1'b1;
        end
      end
      default: o_grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/lieat_general_dfflr.sv
// Generic load-enable flop with synchronous active-low reset to zero.
module lieat_general_dfflr #(
  parameter int DW = 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_lden,
  input  logic [DW-1:0] i_dnxt,
  output logic [DW-1:0] o_qout
);

  logic [DW-1:0] r_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_q <= '0;
    end else if (i_lden) begin
      r_q <= i_dnxt;
    end
  end

  assign o_qout = r_q;

endmodule

// File: rtl/lieat_exu_wbck.sv
// Write-back stage: round-robin merge of ALU and MUL/DIV results into a
// one-entry valid/ready slot that drives the register-file write port.
module lieat_exu_wbck
  import lieat_exu_wbck_pkg::*;
(
  input  logic                  clk,
  input  logic                  rstn,

  input  logic                  alu_wbck_i_valid,
  output logic                  alu_wbck_i_ready,
  input  logic [XLEN-1:0]       alu_wbck_i_pc,
  input  logic [RGIDX_SIZE-1:0] alu_wbck_i_rd,
  input  logic                  alu_wbck_i_wen,
  input  logic [XLEN-1:0]       alu_wbck_i_data,

  input  logic                  muldiv_wbck_i_valid,
  output logic                  muldiv_wbck_i_ready,
  input  logic [XLEN-1:0]       muldiv_wbck_i_pc,
  input  logic [RGIDX_SIZE-1:0] muldiv_wbck_i_rd,
  input  logic                  muldiv_wbck_i_wen,
  input  logic [XLEN-1:0]       muldiv_wbck_i_data,

  output logic                  wbck_o_valid,
  input  logic                  wbck_o_ready,
  output logic [XLEN-1:0]       wbck_o_pc,
  output logic [RGIDX_SIZE-1:0] wbck_o_rd,
  output logic [XLEN-1:0]       wbck_o_data,

  output logic                  rf_wen,
  output logic [RGIDX_SIZE-1:0] rf_waddr,
  output logic [XLEN-1:0]       rf_wdata
);

  // Handshake: a transfer happens on a side exactly when valid & ready are
  // both high at a rising edge; valid never waits on ready, and each input
  // ready is high only for the granted source while the slot can take data.

  logic [1:0]  w_grant;
  logic        w_last_grant;
  logic        w_o_valid;
  logic        w_stage_ready;
  logic        w_alu_acc;
  logic        w_muldiv_acc;
  logic        w_accept;
  logic        w_valid_set;
  logic        w_valid_clr;
  logic        w_next_grant;
  wbck_entry_t w_alu_entry;
  wbck_entry_t w_muldiv_entry;
  wbck_entry_t w_win_entry;
  wbck_entry_t w_slot;

  lieat_exu_wbck_arb u_arb (
    .i_alu_valid    (alu_wbck_i_valid),
    .i_muldiv_valid (muldiv_wbck_i_valid),
    .i_last_grant   (w_last_grant),
    .o_grant        (w_grant)
  );

  assign w_stage_ready = ~w_o_valid | wbck_o_ready;

  // Readies are held low while reset is asserted so nothing looks accepted.
  assign alu_wbck_i_ready    = rstn & w_grant[GNT_ALU]    & w_stage_ready;
  assign muldiv_wbck_i_ready = rstn & w_grant[GNT_MULDIV] & w_stage_ready;

  assign w_alu_acc    = alu_wbck_i_valid    & alu_wbck_i_ready;
  assign w_muldiv_acc = muldiv_wbck_i_valid & muldiv_wbck_i_ready;
  assign w_accept     = w_alu_acc | w_muldiv_acc;

  assign w_alu_entry = '{pc:   alu_wbck_i_pc,
                         rd:   alu_wbck_i_rd,
                         wen:  alu_wbck_i_wen,
                         data: alu_wbck_i_data};

  assign w_muldiv_entry = '{pc:   muldiv_wbck_i_pc,
                            rd:   muldiv_wbck_i_rd,
                            wen:  muldiv_wbck_i_wen,
                            data: muldiv_wbck_i_data};

  assign w_win_entry  = w_grant[GNT_MULDIV] ? w_muldiv_entry : w_alu_entry;
  assign w_next_grant = w_grant[GNT_MULDIV] ? LAST_GRANT_MULDIV : LAST_GRANT_ALU;

  lieat_general_dfflr #(.DW(WBCK_ENTRY_W)) u_slot_dff (
    .clk    (clk),
    .rstn   (rstn),
    .i_lden (w_accept),
    .i_dnxt (w_win_entry),
    .o_qout (w_slot)
  );

  // A drain with a same-cycle accept keeps valid set: no bubble.
  assign w_valid_set = w_accept;
  assign w_valid_clr = ~w_accept & wbck_o_ready;

  lieat_general_dfflr #(.DW(1)) u_valid_dff (
    .clk    (clk),
    .rstn   (rstn),
    .i_lden (w_valid_set | w_valid_clr),
    .i_dnxt (w_valid_set),
    .o_qout (w_o_valid)
  );

  lieat_general_dfflr #(.DW(1)) u_last_grant_dff (
    .clk    (clk),
    .rstn   (rstn),
    .i_lden (w_accept),
    .i_dnxt (w_next_grant),
    .o_qout (w_last_grant)
  );

  assign wbck_o_valid = w_o_valid;
  assign wbck_o_pc    = w_slot.pc;
  assign wbck_o_rd    = w_slot.rd;
  assign wbck_o_data  = w_slot.data;

  assign rf_wen   = rstn & w_o_valid & wbck_o_ready & rf_write_allowed(w_slot.wen, w_slot.rd);
  assign rf_waddr = w_slot.rd;
  assign rf_wdata = w_slot.data;

endmodule

// File: tb/tb_lieat_exu_wbck.sv
// Directed bench for lieat_exu_wbck: arbitration, stall, x0/wen filtering
// and reset behaviour, with hand-computed expectations.
module tb_lieat_exu_wbck;
  import lieat_exu_wbck_pkg::*;

  logic                  clk;
  logic                  rstn;
  logic                  alu_valid, alu_ready, alu_wen;
  logic [XLEN-1:0]       alu_pc, alu_data;
  logic [RGIDX_SIZE-1:0] alu_rd;
  logic                  mul_valid, mul_ready, mul_wen;
  logic [XLEN-1:0]       mul_pc, mul_data;
  logic [RGIDX_SIZE-1:0] mul_rd;
  logic                  o_valid, o_ready;
  logic [XLEN-1:0]       o_pc, o_data;
  logic [RGIDX_SIZE-1:0] o_rd;
  logic                  rf_wen;
  logic [RGIDX_SIZE-1:0] rf_waddr;
  logic [XLEN-1:0]       rf_wdata;

  int n_cmp;
  int n_bad;

  lieat_exu_wbck dut (
    .clk                 (clk),
    .rstn                (rstn),
    .alu_wbck_i_valid    (alu_valid),
    .alu_wbck_i_ready    (alu_ready),
    .alu_wbck_i_pc       (alu_pc),
    .alu_wbck_i_rd       (alu_rd),
    .alu_wbck_i_wen      (alu_wen),
    .alu_wbck_i_data     (alu_data),
    .muldiv_wbck_i_valid (mul_valid),
    .muldiv_wbck_i_ready (mul_ready),
    .muldiv_wbck_i_pc    (mul_pc),
    .muldiv_wbck_i_rd    (mul_rd),
    .muldiv_wbck_i_wen   (mul_wen),
    .muldiv_wbck_i_data  (mul_data),
    .wbck_o_valid        (o_valid),
    .wbck_o_ready        (o_ready),
    .wbck_o_pc           (o_pc),
    .wbck_o_rd           (o_rd),
    .wbck_o_data         (o_data),
    .rf_wen              (rf_wen),
    .rf_waddr            (rf_waddr),
    .rf_wdata            (rf_wdata)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- source contract monitor ----------------
  logic                  p_rstn, p_alu_v, p_alu_r, p_mul_v, p_mul_r;
  logic [XLEN-1:0]       p_alu_d, p_mul_d;
  logic [RGIDX_SIZE-1:0] p_alu_rd, p_mul_rd;
  initial begin
    p_rstn = 1'b0; p_alu_v = 1'b0; p_alu_r = 1'b0; p_mul_v = 1'b0; p_mul_r = 1'b0;
    p_alu_d = '0; p_mul_d = '0; p_alu_rd = '0; p_mul_rd = '0;
  end
  always @(posedge clk) begin
    if (p_rstn && rstn && p_alu_v && !p_alu_r) begin
      n_cmp++;
      if (!alu_valid || alu_data !== p_alu_d || alu_rd !== p_alu_rd) begin
        n_bad++;
        $display("FAIL alu_contract: valid=%b data=%h rd=%0d required held data=%h rd=%0d",
                 alu_valid, alu_data, alu_rd, p_alu_d, p_alu_rd);
      end
    end
    if (p_rstn && rstn && p_mul_v && !p_mul_r) begin
      n_cmp++;
      if (!mul_valid || mul_data !== p_mul_d || mul_rd !== p_mul_rd) begin
        n_bad++;
        $display("FAIL mul_contract: valid=%b data=%h rd=%0d required held data=%h rd=%0d",
                 mul_valid, mul_data, mul_rd, p_mul_d, p_mul_rd);
      end
    end
    p_rstn = rstn;
    p_alu_v = alu_valid; p_alu_r = alu_ready; p_alu_d = alu_data; p_alu_rd = alu_rd;
    p_mul_v = mul_valid; p_mul_r = mul_ready; p_mul_d = mul_data; p_mul_rd = mul_rd;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic drive_alu(input logic v, input logic [XLEN-1:0] pc,
                           input logic [RGIDX_SIZE-1:0] rd, input logic wen,
                           input logic [XLEN-1:0] data);
    alu_valid = v; alu_pc = pc; alu_rd = rd; alu_wen = wen; alu_data = data;
  endtask

  task automatic drive_mul(input logic v, input logic [XLEN-1:0] pc,
                           input logic [RGIDX_SIZE-1:0] rd, input logic wen,
                           input logic [XLEN-1:0] data);
    mul_valid = v; mul_pc = pc; mul_rd = rd; mul_wen = wen; mul_data = data;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    step();
    step();
    rstn = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rstn = 1'b0;
    o_ready = 1'b0;
    drive_alu(1'b1, 32'h40, 5'd1, 1'b1, 32'h99);
    drive_mul(1'b0, '0, '0, 1'b0, '0);
    step();
    samp();
    n_cmp++;
    if (alu_ready !== 1'b0) begin
      n_bad++; $display("FAIL reset_alu_ready: got %b required 0", alu_ready);
    end
    step();
    drive_alu(1'b0, '0, '0, 1'b0, '0);
    samp();
    n_cmp++;
    if ({o_valid, alu_ready, mul_ready, rf_wen} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_flags: got %b required 0000", {o_valid, alu_ready, mul_ready, rf_wen});
    end
    n_cmp++;
    if (o_pc !== '0 || o_data !== '0 || o_rd !== '0 || rf_waddr !== '0 || rf_wdata !== '0) begin
      n_bad++; $display("FAIL reset_payload: pc=%h data=%h rd=%0d waddr=%0d wdata=%h required all 0",
                        o_pc, o_data, o_rd, rf_waddr, rf_wdata);
    end
    rstn = 1'b1;
    step();
  endtask

  task automatic test_alu_back_to_back();
    o_ready = 1'b1;
    drive_alu(1'b1, 32'h100, 5'd5, 1'b1, 32'h11);
    samp();
    n_cmp++;
    if (alu_ready !== 1'b1) begin
      n_bad++; $display("FAIL b2b_ready0: got %b required 1", alu_ready);
    end
    step();
    drive_alu(1'b1, 32'h104, 5'd6, 1'b1, 32'h22);
    samp();
    n_cmp++;
    if (o_valid !== 1'b1 || o_data !== 32'h11 || rf_wen !== 1'b1 || rf_waddr !== 5'd5 || alu_ready !== 1'b1) begin
      n_bad++; $display("FAIL b2b_first: valid=%b data=%h rf_wen=%b waddr=%0d ready=%b required 1 11 1 5 1",
                        o_valid, o_data, rf_wen, rf_waddr, alu_ready);
    end
    step();
    drive_alu(1'b0, '0, '0, 1'b0, '0);
    samp();
    n_cmp++;
    if (o_valid !== 1'b1 || o_data !== 32'h22 || rf_wen !== 1'b1 || rf_waddr !== 5'd6 || o_pc !== 32'h104) begin
      n_bad++; $display("FAIL b2b_second: valid=%b data=%h rf_wen=%b waddr=%0d pc=%h required 1 22 1 6 104",
                        o_valid, o_data, rf_wen, rf_waddr, o_pc);
    end
    step();
    samp();
    n_cmp++;
    if (o_valid !== 1'b0 || rf_wen !== 1'b0) begin
      n_bad++; $display("FAIL b2b_drained: valid=%b rf_wen=%b required 0 0", o_valid, rf_wen);
    end
    step();
  endtask

  task automatic test_tie_after_reset();
    o_ready = 1'b1;
    do_reset();
    drive_alu(1'b1, 32'h200, 5'd10, 1'b1, 32'hA);
    drive_mul(1'b1, 32'h300, 5'd11, 1'b1, 32'hB);
    samp();
    n_cmp++;
    if (mul_ready !== 1'b1 || alu_ready !== 1'b0) begin
      n_bad++; $display("FAIL tie_grant: mul_ready=%b alu_ready=%b required 1 0", mul_ready, alu_ready);
    end
    step();
    drive_mul(1'b0, '0, '0, 1'b0, '0);
    samp();
    n_cmp++;
    if (o_valid !== 1'b1 || o_data !== 32'hB || rf_waddr !== 5'd11 || alu_ready !== 1'b1) begin
      n_bad++; $display("FAIL tie_first: valid=%b data=%h waddr=%0d alu_ready=%b required 1 b 11 1",
                        o_valid, o_data, rf_waddr, alu_ready);
    end
    step();
    drive_alu(1'b0, '0, '0, 1'b0, '0);
    samp();
    n_cmp++;
    if (o_valid !== 1'b1 || o_data !== 32'hA || o_pc !== 32'h200) begin
      n_bad++; $display("FAIL tie_second: valid=%b data=%h pc=%h required 1 a 200", o_valid, o_data, o_pc);
    end
    n_cmp++;
    if (dut.w_last_grant !== LAST_GRANT_ALU) begin
      n_bad++; $display("FAIL tie_last_grant: got %b required 0", dut.w_last_grant);
    end
    step();
  endtask

  task automatic test_stall();
    o_ready = 1'b0;
    drive_alu(1'b1, 32'h400, 5'd7, 1'b1, 32'h31);
    step();
    drive_alu(1'b1, 32'h404, 5'd8, 1'b1, 32'h32);
    for (int i = 0; i < 3; i++) begin
      samp();
      n_cmp++;
      if (alu_ready !== 1'b0 || o_valid !== 1'b1 || o_data !== 32'h31 || rf_wen !== 1'b0) begin
        n_bad++; $display("FAIL stall_hold[%0d]: ready=%b valid=%b data=%h rf_wen=%b required 0 1 31 0",
                          i, alu_ready, o_valid, o_data, rf_wen);
      end
      step();
    end
    o_ready = 1'b1;
    samp();
    n_cmp++;
    if (alu_ready !== 1'b1 || rf_wen !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h31) begin
      n_bad++; $display("FAIL stall_release: ready=%b rf_wen=%b waddr=%0d wdata=%h required 1 1 7 31",
                        alu_ready, rf_wen, rf_waddr, rf_wdata);
    end
    step();
    drive_alu(1'b0, '0, '0, 1'b0, '0);
    samp();
    n_cmp++;
    if (o_valid !== 1'b1 || o_data !== 32'h32 || rf_waddr !== 5'd8) begin
      n_bad++; $display("FAIL stall_reload: valid=%b data=%h waddr=%0d required 1 32 8", o_valid, o_data, rf_waddr);
    end
    step();
    samp();
    n_cmp++;
    if (o_valid !== 1'b0) begin
      n_bad++; $display("FAIL stall_drained: valid=%b required 0", o_valid);
    end
    step();
  endtask

  task automatic test_x0_write();
    o_ready = 1'b1;
    drive_alu(1'b1, 32'h500, 5'd0, 1'b1, 32'hDEAD);
    step();
    drive_alu(1'b0, '0, '0, 1'b0, '0);
    samp();
    n_cmp++;
    if (o_valid !== 1'b1 || rf_wen !== 1'b0 || rf_wdata !== 32'hDEAD || rf_waddr !== 5'd0) begin
      n_bad++; $display("FAIL x0_present: valid=%b rf_wen=%b wdata=%h waddr=%0d required 1 0 dead 0",
                        o_valid, rf_wen, rf_wdata, rf_waddr);
    end
    step();
    samp();
    n_cmp++;
    if (o_valid !== 1'b0) begin
      n_bad++; $display("FAIL x0_drained: valid=%b required 0", o_valid);
    end
    step();
  endtask

  task automatic test_wen_zero();
    o_ready = 1'b1;
    drive_mul(1'b1, 32'h600, 5'd3, 1'b0, 32'h55);
    samp();
    n_cmp++;
    if (mul_ready !== 1'b1) begin
      n_bad++; $display("FAIL wen0_ready: got %b required 1", mul_ready);
    end
    step();
    drive_mul(1'b0, '0, '0, 1'b0, '0);
    samp();
    n_cmp++;
    if (o_valid !== 1'b1 || rf_wen !== 1'b0 || o_rd !== 5'd3 || o_data !== 32'h55) begin
      n_bad++; $display("FAIL wen0_present: valid=%b rf_wen=%b rd=%0d data=%h required 1 0 3 55",
                        o_valid, rf_wen, o_rd, o_data);
    end
    step();
    samp();
    n_cmp++;
    if (o_valid !== 1'b0 || rf_wen !== 1'b0) begin
      n_bad++; $display("FAIL wen0_pulse: valid=%b rf_wen=%b required 0 0", o_valid, rf_wen);
    end
    step();
  endtask

  task automatic test_rr_tie();
    // MUL/DIV won last, so the ALU should take this tie.
    o_ready = 1'b1;
    drive_alu(1'b1, 32'h700, 5'd12, 1'b1, 32'hC1);
    drive_mul(1'b1, 32'h710, 5'd13, 1'b1, 32'hC2);
    samp();
    n_cmp++;
    if (alu_ready !== 1'b1 || mul_ready !== 1'b0) begin
      n_bad++; $display("FAIL rr_grant: alu_ready=%b mul_ready=%b required 1 0", alu_ready, mul_ready);
    end
    step();
    drive_alu(1'b0, '0, '0, 1'b0, '0);
    samp();
    n_cmp++;
    if (o_data !== 32'hC1 || mul_ready !== 1'b1) begin
      n_bad++; $display("FAIL rr_first: data=%h mul_ready=%b required c1 1", o_data, mul_ready);
    end
    step();
    drive_mul(1'b0, '0, '0, 1'b0, '0);
    samp();
    n_cmp++;
    if (o_data !== 32'hC2 || o_valid !== 1'b1) begin
      n_bad++; $display("FAIL rr_second: data=%h valid=%b required c2 1", o_data, o_valid);
    end
    step();
  endtask

  task automatic test_reset_mid_stall();
    o_ready = 1'b0;
    drive_mul(1'b1, 32'h800, 5'd9, 1'b1, 32'h77);
    step();
    drive_mul(1'b0, '0, '0, 1'b0, '0);
    samp();
    n_cmp++;
    if (o_valid !== 1'b1 || o_data !== 32'h77) begin
      n_bad++; $display("FAIL rst_stall_full: valid=%b data=%h required 1 77", o_valid, o_data);
    end
    step();
    rstn = 1'b0;
    o_ready = 1'b1;
    samp();
    n_cmp++;
    if (rf_wen !== 1'b0) begin
      n_bad++; $display("FAIL rst_cycle_rf_wen: got %b required 0", rf_wen);
    end
    step();
    samp();
    n_cmp++;
    if (o_valid !== 1'b0 || rf_wen !== 1'b0 || o_data !== '0) begin
      n_bad++; $display("FAIL rst_stall_cleared: valid=%b rf_wen=%b data=%h required 0 0 0", o_valid, rf_wen, o_data);
    end
    step();
    rstn = 1'b1;
    drive_alu(1'b1, 32'h900, 5'd14, 1'b1, 32'hE1);
    drive_mul(1'b1, 32'h910, 5'd15, 1'b1, 32'hE2);
    samp();
    n_cmp++;
    if (mul_ready !== 1'b1 || alu_ready !== 1'b0) begin
      n_bad++; $display("FAIL rst_tie_grant: mul_ready=%b alu_ready=%b required 1 0", mul_ready, alu_ready);
    end
    step();
    drive_mul(1'b0, '0, '0, 1'b0, '0);
    samp();
    n_cmp++;
    if (o_data !== 32'hE2 || rf_waddr !== 5'd15) begin
      n_bad++; $display("FAIL rst_tie_first: data=%h waddr=%0d required e2 15", o_data, rf_waddr);
    end
    step();
    drive_alu(1'b0, '0, '0, 1'b0, '0);
    samp();
    n_cmp++;
    if (o_data !== 32'hE1 || rf_waddr !== 5'd14) begin
      n_bad++; $display("FAIL rst_tie_second: data=%h waddr=%0d required e1 14", o_data, rf_waddr);
    end
    step();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_cmp = 0;
    n_bad = 0;
    rstn = 1'b0;
    o_ready = 1'b0;
    drive_alu(1'b0, '0, '0, 1'b0, '0);
    drive_mul(1'b0, '0, '0, 1'b0, '0);
    #1;
    test_reset();
    test_alu_back_to_back();
    test_tie_after_reset();
    test_stall();
    test_x0_write();
    test_wen_zero();
    test_rr_tie();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
